fir_out_conditioner: RTL and testbench
======================================

# fir_out_conditioner

Receiving end of the FIR filter output path. Takes the filter's 64-bit signed Q31-aligned result stream and discards the start-up transient. It then decimates, saturates each kept sample to 32-bit Q31 and buffers it in a small FIFO. Downstream consumers read it over a valid/ready handshake. It sits directly after the filter and before any serializer or DMA sink.

## Interface
Parameters:
- IN_W, 64, input sample width (signed).
- OUT_W, 32, output sample width (signed Q31).
- SKIP, 102, number of valid input samples discarded after reset/clear (filter fill); 0 allowed.
- DECIM, 1, decimation factor, 1..16.
- DEPTH, 8, FIFO depth, power of two, ≥2.

Ports:
- Reset and clock (already decided): reset rst, asynchronous, active-high; clock clk.
- clr, in, 1, synchronous soft clear.
- in_valid, in, 1, in_data holds a new filter output this cycle.
- in_data, in, IN_W, signed filter output (already shifted to Q31 scale).
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, consumer accepts head.
- out_data, out, OUT_W, FIFO head sample.
- out_sat, out, 1, head sample was clipped.
- level, out, $clog2(DEPTH)+1, FIFO occupancy.
- sat_count, out, 16, clipped kept samples, saturating at 0xFFFF.
- drop_count, out, 16, samples lost to FIFO full, saturating at 0xFFFF.
- warm, out, 1, high in RUN state.

## Operation
- FSM has two states, WARMUP and RUN. The reset/clr state is WARMUP, or RUN directly when SKIP=0.
- WARMUP: a skip counter counts in_valid cycles. These samples are discarded and not counted anywhere. On the SKIP-th valid sample the FSM moves to RUN; that sample is discarded too.
- RUN: a phase counter runs 0..DECIM-1 and advances on each in_valid, wrapping to 0. The sample is kept when phase==0 before the increment, so the 1st, (DECIM+1)th, … samples are kept.
- Saturation, applied to kept samples:
  - If in_data[IN_W-1:OUT_W-1] is all equal, out = in_data[OUT_W-1:0], sat=0.
  - Otherwise, if negative, out = 0x80000000; if positive, out = 0x7FFFFFFF; sat=1, and sat_count increments.
- Pipeline: a kept sample is captured into a stage register (data, sat, valid). The next cycle the stage pushes into the FIFO.
- FIFO:
  - Push when the stage is valid and either the FIFO is not full, or it is full and a pop happens this cycle (the simultaneous push+pop at full succeeds).
  - If the stage is valid, the FIFO is full and there is no pop, the sample is dropped and drop_count increments.
  - Pop when out_valid && out_ready.
  - out_data and out_sat are driven from the head entry; out_valid = level!=0.
  - Pointers wrap modulo DEPTH.
- clr, synchronous, has priority over everything in the same cycle:
  - Empties the FIFO, invalidates the stage, zeroes the counters and phase, and returns the FSM to its reset state.
  - A sample or pop presented with clr is ignored.
- rst, asynchronous: same effect as clr, immediately, including mid-handshake.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, level=0, sat_count=0, drop_count=0; warm=0, or 1 if SKIP=0.
- Latency: a kept sample presented in cycle t gives out_valid=1 in cycle t+2 with an empty FIFO; level updates in the same cycle.
- Throughput: one input sample per cycle is sustained indefinitely when out_ready=1 continuously; no drops.
- out_data/out_sat are stable while out_valid=1 and out_ready=0.
- sat_count updates on the stage capture edge; drop_count updates on the push-attempt edge.
- warm rises the cycle after the SKIP-th valid sample.

## Structure
- Shared package fir_pkg:
  - typedef sample_q31_t (signed [31:0]) and acc_t (signed [63:0]).
  - Constants Q31_MAX = 32'h7FFFFFFF and Q31_MIN = 32'h80000000.
  - Enum cond_state_t {WARMUP, RUN}.
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/level, with the push-on-full-with-pop rule.
- Saturation, FSM and counters are inline.

## Test plan
- SKIP=3, DECIM=1, inputs 1,2,3,4,5 each cycle, out_ready=1 → outputs 4,5; first out_valid appears 2 cycles after the sample 4 cycle; warm rises after the 3rd sample.
- DECIM=4, SKIP=0, inputs 0..11 → outputs 0,4,8; no others.
- Inputs 0x0000_0000_8000_0000, -0x0000_0000_8000_0001, 0x7FFFFFFF → 0x7FFFFFFF sat=1, 0x80000000 sat=1, 0x7FFFFFFF sat=0; sat_count=2.
- DEPTH=8, out_ready=0, 10 kept samples → level=8, drop_count=2, and the first 8 are retained in order. Then raise out_ready while still pushing at full → no additional drop.
- clr asserted while level=5 and in_valid=1 → next cycle level=0, out_valid=0, counters 0, warm per SKIP; the sample presented with clr never appears.
- rst asserted asynchronously mid-stream with out_valid=1 → all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR filter output path.
package fir_pkg;

  typedef logic signed [31:0] sample_q31_t;
  typedef logic signed [63:0] acc_t;

  localparam sample_q31_t Q31_MAX = 32'h7FFF_FFFF;
  localparam sample_q31_t Q31_MIN = 32'h8000_0000;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } cond_state_t;

  // 16-bit event counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_conditioner.sv
// FIR output conditioner: drops the filter fill transient, decimates, saturates to Q31
// and buffers kept samples for a valid/ready consumer.
module fir_out_conditioner
  import fir_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int SKIP  = 102,
  parameter int DECIM = 1,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               sat_count,
  output logic [15:0]               drop_count,
  output logic                      warm
);

  localparam int SKW = (SKIP < 2) ? 1 : $clog2(SKIP + 1);
  localparam int PW  = (DECIM < 2) ? 1 : $clog2(DECIM);
  localparam cond_state_t RST_STATE = (SKIP == 0) ? RUN : WARMUP;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(Q31_MAX);
  localparam logic [OUT_W-1:0] OUT_MIN = OUT_W'(Q31_MIN);

  cond_state_t state, state_nx;
  logic [SKW-1:0]      skip_left;
  logic [PW-1:0]       phase;
  logic                skip_dec;
  logic                keep;

  logic [IN_W-OUT_W:0] upper;
  logic                in_range;
  logic                sat_hit;
  logic [OUT_W-1:0]    sat_data;

  logic                stg_valid;
  logic                stg_sat;
  logic [OUT_W-1:0]    stg_data;

  logic                pop_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    skip_dec = 1'b0;
    keep     = 1'b0;
    unique case (state)
      WARMUP: begin
        if (in_valid) begin
          skip_dec = 1'b1;
          if (skip_left == SKW'(1)) state_nx = RUN;
        end
      end
      RUN:     keep = in_valid && (phase == '0);
      default: state_nx = RST_STATE;
    endcase
    if (clr) begin
      state_nx = RST_STATE;
      skip_dec = 1'b0;
      keep     = 1'b0;
    end
  end

  // Phase is a down-counter: zero marks the kept sample, then it reloads DECIM-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_left <= SKW'(SKIP);
      phase     <= '0;
    end else if (clr) begin
      skip_left <= SKW'(SKIP);
      phase     <= '0;
    end else begin
      if (skip_dec) skip_left <= skip_left - SKW'(1);
      if (state == RUN && in_valid)
        phase <= (phase == '0) ? PW'(DECIM - 1) : phase - PW'(1);
    end
  end

  assign upper    = in_data[IN_W-1:OUT_W-1];
  assign in_range = (&upper) || !(|upper);
  assign sat_hit  = !in_range;
  assign sat_data = in_range ? in_data[OUT_W-1:0] : (in_data[IN_W-1] ? OUT_MIN : OUT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_sat   <= 1'b0;
      stg_data  <= '0;
      sat_count <= '0;
    end else if (clr) begin
      stg_valid <= 1'b0;
      sat_count <= '0;
    end else begin
      stg_valid <= keep;
      if (keep) begin
        stg_data <= sat_data;
        stg_sat  <= sat_hit;
        if (sat_hit) sat_count <= sat_inc16(sat_count);
      end
    end
  end

  assign pop_req = out_valid && out_ready;
  assign drop    = stg_valid && fifo_full && !pop_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       drop_count <= '0;
    else if (clr)  drop_count <= '0;
    else if (drop) drop_count <= sat_inc16(drop_count);
  end

  sync_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (stg_valid),
    .pop   (pop_req),
    .wdata ({stg_sat, stg_data}),
    .rdata ({out_sat, out_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_valid = !fifo_empty;
  assign warm      = (state == RUN);

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Scoreboard bench for fir_out_conditioner: two configurations share one stimulus stream.
module tb_fir_out_conditioner;

  localparam int DEPTH = 8;
  localparam int SKIP_P  [2] = '{3, 0};
  localparam int DECIM_P [2] = '{1, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;

  logic [1:0]  ov, os, wm;
  logic [31:0] od [2];
  logic [3:0]  lv [2];
  logic [15:0] sc [2];
  logic [15:0] dc [2];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    logic        s;
  } exp_t;

  exp_t expq [2][$];
  int   nv    [2];
  int   mlvl  [2];
  int   msat  [2];
  int   mdrop [2];
  bit   mpop  [2];
  bit   mstg_v[2];
  exp_t mstg  [2];

  always #5 clk = ~clk;

  fir_out_conditioner #(.IN_W(64), .OUT_W(32), .SKIP(3), .DECIM(1), .DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_sat(os[0]),
    .level(lv[0]), .sat_count(sc[0]), .drop_count(dc[0]), .warm(wm[0])
  );

  fir_out_conditioner #(.IN_W(64), .OUT_W(32), .SKIP(0), .DECIM(4), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_sat(os[1]),
    .level(lv[1]), .sat_count(sc[1]), .drop_count(dc[1]), .warm(wm[1])
  );

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference saturation by value range, not by bit pattern.
  task automatic ref_sample(input logic [63:0] x, output exp_t e);
    longint v;
    v = $signed(x);
    if (v > 64'sd2147483647) begin
      e.d = 32'h7FFF_FFFF; e.s = 1'b1;
    end else if (v < -64'sd2147483648) begin
      e.d = 32'h8000_0000; e.s = 1'b1;
    end else begin
      e.d = x[31:0]; e.s = 1'b0;
    end
  endtask

  // Reference model: sample index since clear decides keep; FIFO tracked as an occupancy count.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || clr) begin
        nv[k] = 0; mlvl[k] = 0; msat[k] = 0; mdrop[k] = 0; mstg_v[k] = 1'b0;
        expq[k].delete();
      end else begin
        mpop[k] = (mlvl[k] != 0) && out_ready;
        if (mstg_v[k]) begin
          if (mlvl[k] < DEPTH || mpop[k]) begin
            expq[k].push_back(mstg[k]);
            mlvl[k]++;
          end else if (mdrop[k] < 65535) begin
            mdrop[k]++;
          end
        end
        if (mpop[k]) mlvl[k]--;
        mstg_v[k] = 1'b0;
        if (in_valid) begin
          if (nv[k] >= SKIP_P[k] && ((nv[k] - SKIP_P[k]) % DECIM_P[k]) == 0) begin
            ref_sample(in_data, mstg[k]);
            mstg_v[k] = 1'b1;
            if (mstg[k].s && msat[k] < 65535) msat[k]++;
          end
          nv[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("level", k, 64'(lv[k]), 64'(mlvl[k]));
      chk("out_valid", k, 64'(ov[k]), 64'(mlvl[k] != 0));
      chk("warm", k, 64'(wm[k]), 64'(nv[k] >= SKIP_P[k]));
      chk("sat_count", k, 64'(sc[k]), 64'(msat[k]));
      chk("drop_count", k, 64'(dc[k]), 64'(mdrop[k]));
      if (ov[k] === 1'b1 && !rst) begin
        if (expq[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output dut%0d: got data %0h with nothing expected", k, od[k]);
        end else begin
          chk("out_data", k, 64'(od[k]), 64'(expq[k][0].d));
          chk("out_sat", k, 64'(os[k]), 64'(expq[k][0].s));
          if (out_ready && !clr) void'(expq[k].pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [63:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1'b0, '0);
    clr = 1'b0;
  endtask

  function automatic logic [63:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {{32{r[31]}}, r};
      1:       return {$urandom, $urandom};
      2:       return 64'h0000_0000_8000_0000 - 64'($urandom_range(0, 2));
      default: return 64'hFFFF_FFFF_8000_0000 + 64'($urandom_range(0, 2)) - 64'd1;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_out_data", k, 64'(od[k]), 64'd0);
      chk("reset_out_sat", k, 64'(os[k]), 64'd0);
    end
    rst = 1'b0;

    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) cyc(1'b1, 64'(i));
    idle(6);

    do_clr();
    for (int i = 0; i < 12; i++) cyc(1'b1, 64'(i));
    idle(6);

    do_clr();
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'd0);
    cyc(1'b1, 64'h0000_0000_8000_0000);
    cyc(1'b1, 64'hFFFF_FFFF_7FFF_FFFF);
    cyc(1'b1, 64'h0000_0000_7FFF_FFFF);
    idle(4);
    chk("sat_count_directed", 0, 64'(sc[0]), 64'd2);

    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) cyc(1'b1, 64'(100 + 7 * i));
    idle(2);
    chk("full_level", 0, 64'(lv[0]), 64'd8);
    chk("full_drops", 0, 64'(dc[0]), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'(500 + i));
    idle(12);
    chk("no_drop_with_pop", 0, 64'(dc[0]), 64'd2);

    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'(40 + i));
    idle(3);
    chk("pre_clr_level", 0, 64'(lv[0]), 64'd5);
    clr = 1'b1;
    cyc(1'b1, 64'h55);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_level", 0, 64'(lv[0]), 64'd0);
    chk("clr_warm0", 0, 64'(wm[0]), 64'd0);
    chk("clr_warm1", 1, 64'(wm[1]), 64'd1);
    out_ready = 1'b1;
    idle(4);

    for (int c = 0; c < 1500; c++) begin
      if ((c % 100) == 0) out_ready = 1'b1;
      if ((c % 100) == 50) out_ready = 1'b0;
      if ((c % 100) >= 70) out_ready = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 9) < 7, rand_data());
      clr = 1'b0;
    end
    idle(6);

    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) cyc(1'b1, 64'(i) | 64'hFFFF_FFFF_0000_0000);
    idle(3);
    chk("pre_rst_valid", 0, 64'(ov[0]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_out_valid", k, 64'(ov[k]), 64'd0);
      chk("arst_out_data", k, 64'(od[k]), 64'd0);
      chk("arst_out_sat", k, 64'(os[k]), 64'd0);
      chk("arst_level", k, 64'(lv[k]), 64'd0);
      chk("arst_sat_count", k, 64'(sc[k]), 64'd0);
      chk("arst_drop_count", k, 64'(dc[k]), 64'd0);
      chk("arst_warm", k, 64'(wm[k]), 64'(SKIP_P[k] == 0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, rand_data());
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
